// File: rtl/midi_note_tx.sv
// midi_note_tx: turns note events into 3-byte MIDI Note On/Off messages and
// sends them on a MIDI OUT line (8N1, LSB first, CLKS_PER_BIT clocks per bit).
// The bit-timing serializer is built in, so no external uart core is needed.
//
// Optional build macro: MIDI_RUNNING_STATUS_EN
//   When it is defined, the block remembers the last status byte it sent. An
//   event whose status matches that byte is sent as two bytes (data1, data2),
//   and the status byte is skipped.
//   When it is undefined, every message carries its status byte.
//
// resetq is a synchronous, active-high reset. Asserting it during a message
// aborts the message at once and returns tx high on the same edge.

module midi_note_tx #(
  parameter int         CLKS_PER_BIT         = 384,
  parameter logic [3:0] DEFAULT_CHANNEL_MASK = 4'hF
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       note_on,
  input  logic [3:0] channel,
  input  logic [6:0] note,
  input  logic [6:0] velocity,
  output logic       tx,
  output logic       busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [7:0]    status_q, data1_q, data2_q;
  logic          armed_q;
  logic          tx_q, tx_d;
  logic          tick;
  logic          accept;
  logic [7:0]    status_in;
  logic [1:0]    start_idx;
  logic [7:0]    cur_byte;

  // Status byte 0x8n (note off) or 0x9n (note on), with the channel masked.
  assign status_in = {3'b100, note_on, channel & DEFAULT_CHANNEL_MASK};
  assign tick      = (timer_q == TIMER_LAST);
  assign accept    = in_valid && in_ready;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_q;
  logic       last_valid_q;

  // When the status matches the last one sent, start at data1.
  assign start_idx = (last_valid_q && (last_status_q == status_in)) ? 2'd1 : 2'd0;

  // Running-status memory: reset invalidates it, and every accepted event updates it.
  always_ff @(posedge clk) begin
    if (resetq) begin
      last_valid_q  <= 1'b0;
      last_status_q <= 8'h00;
    end else if (accept) begin
      last_valid_q  <= 1'b1;
      last_status_q <= status_in;
    end
  end
`else
  assign start_idx = 2'd0;
`endif

  // State register: reset has priority and aborts any message in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments, so
    // every register in this file samples values from before the edge.
    if (resetq) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: frame sequencing plus the bit and byte indices.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          byte_d  = start_idx;
          bit_d   = 3'd0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (byte_q < 2'd2) begin
            byte_d  = byte_q + 2'd1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: handshake and busy flags, and the next line level for tx.
  always_comb begin
    busy     = (state_q != IDLE);
    in_ready = (state_q == IDLE) && armed_q;
    unique case (byte_d)
      2'd0:    cur_byte = status_q;
      2'd1:    cur_byte = data1_q;
      default: cur_byte = data2_q;
    endcase
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  // Bit timer, indices, ready arming and the registered tx line.
  always_ff @(posedge clk) begin
    if (resetq) begin
      timer_q <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      armed_q <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      timer_q <= (state_q == IDLE || tick) ? '0 : timer_q + TW'(1);
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      armed_q <= 1'b1;
      tx_q    <= tx_d;
    end
  end

  // Message payload, captured when an event is accepted.
  always_ff @(posedge clk) begin
    // NOTE: the payload registers have no reset. They are read only after an
    // accept has loaded them, so resetting them would add logic and no safety.
    if (accept) begin
      status_q <= status_in;
      data1_q  <= {1'b0, note};
      data2_q  <= {1'b0, velocity};
    end
  end

  assign tx = tx_q;

endmodule

// File: doc/midi_note_tx.md
Name: midi_note_tx

Overview:
Encodes note events into 3-byte MIDI Note On/Note Off messages and serializes them on a MIDI OUT line (8N1, LSB first, 31250 baud). It is the transmit-side counterpart of the MIDI note-on parser/synth path and includes its own bit-timing serializer, so it has no dependency on the shared uart core. It sits between event sources (buttons, a sequencer, a MIDI-thru path) and the board's TX pin.

Parameters:
CLKS_PER_BIT, 384, clock cycles per serial bit (12 MHz / 31250); must be >= 2.
DEFAULT_CHANNEL_MASK, 4'hF, ANDed with the channel input (4'h0 forces channel 1).

Ports:
clk  input  1  system clock
resetq  input  1  synchronous reset, active-high
in_valid  input  1  event request
in_ready  output  1  block can accept an event this cycle
note_on  input  1  1 = Note On (status 0x9n), 0 = Note Off (status 0x8n)
channel  input  4  MIDI channel n (0-15)
note  input  7  note number
velocity  input  7  velocity
tx  output  1  serial MIDI line, idle high
busy  output  1  high from acceptance until the last stop bit completes

Behaviour:
- Reset: resetq is sampled only on a rising clk edge. In the cycle after reset is asserted: tx=1, busy=0, in_ready=0 while resetq is high, state=IDLE, running-status register invalid. After reset is released, in_ready=1 starting on the next cycle.
- Handshake: an event is accepted when in_valid && in_ready are both high on a clk edge. All inputs are latched on that edge, and later changes to them are ignored. in_ready is high only in IDLE and is low from the cycle after acceptance. in_valid with in_ready low: the event is neither latched nor dropped silently; the source must hold it.
- Encoding: status = {1, ~note_on? 3'b000 : 3'b001, channel & DEFAULT_CHANNEL_MASK}, i.e. 0x8n or 0x9n. data1 = {0, note}, data2 = {0, velocity}. Bit 7 of the data bytes is always 0.
- States: IDLE -> START -> DATA -> STOP -> (next byte ? START : IDLE).
  - IDLE: tx=1. On acceptance, go to START with byte_idx=0.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each held for CLKS_PER_BIT cycles; a 3-bit bit counter.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx < 2, increment it and go to START. Otherwise go to IDLE.
- Latency: tx falls on the first edge after acceptance. Bytes are sent back-to-back with no idle gap. A full message takes exactly 30*CLKS_PER_BIT cycles.
- busy deasserts, and in_ready asserts, in the cycle after the final stop-bit period ends. A new event accepted in that cycle starts its start bit on the next edge, so the minimum inter-message idle is 1 cycle.
- The bit timer counts 0..CLKS_PER_BIT-1 and wraps. Its width is clog2(CLKS_PER_BIT).
- Reset mid-message aborts immediately. tx returns high on that edge, with no partial byte completion. Receivers see a framing error, which is acceptable.
- tx is driven from a register and is glitch-free.

Optional Feature:
MIDI_RUNNING_STATUS_EN
- Defined: the block keeps a last_status register, which is invalid after reset. If the latched status equals a valid last_status, the status byte is skipped: the message is 2 bytes, takes 20*CLKS_PER_BIT cycles, and starts at byte_idx=1. last_status is updated on every accepted event. A reset mid-message invalidates last_status.
- Undefined: every message always carries its status byte, and there is no last_status register.

Test Plan:
1. CLKS_PER_BIT=4, accept note_on=1, channel=0, note=0x3C, velocity=0x64 -> tx carries bytes 0x90, 0x3C, 0x64 (start 0, LSB first, stop 1). tx falls 1 cycle after acceptance, busy is high for 120 cycles, and in_ready returns on cycle 121.
2. note_on=0, channel=9, note=0x24, velocity=0x40 -> bytes 0x89, 0x24, 0x40. Also drive note=7'h7F -> data1=0x7F, and bit 7 of every data byte is 0.
3. Hold in_valid high with two different events queued by the source -> the second is accepted exactly on the cycle in_ready returns, with a 1-cycle idle gap between messages and no bytes lost or duplicated.
4. Assert resetq for 1 cycle midway through data1 -> tx=1 on the next edge, busy=0, in_ready=1 the cycle after release, and the next event sends a full 3-byte message.
5. Change note/velocity/channel inputs during transmission -> the transmitted bytes match the values latched at acceptance.
6. MIDI_RUNNING_STATUS_EN defined: send 0x90/0x3C/0x64, then 0x90/0x40/0x64 -> the second message is 0x40, 0x64 only (80 cycles at CLKS_PER_BIT=4). A third event on channel 1 sends 0x91 again. After reset, the first event always includes its status byte.
